// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the memory stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: XLEN default, register-address width, memory-stage FSM states,
// word-alignment mask and an alignment helper.
package riscv_pipe_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ADDR_W   = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_word_aligned(input logic [1:0] addr_lo);
        return (addr_lo & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts BUSY cycles without a memory response; flags the last permitted one.
// Latency: tc_o is combinational from the registered count.
// Backpressure: none; clr_i takes priority over en_i.
// Ports: clock, reset_n (async active-low), clr_i (zero the count),
//        en_i (increment), tc_o (count == TIMEOUT_CYCLES-1).
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: word loads/stores over a ready/valid bus, registered MEM/WB outputs.
// Latency: 1 cycle for ALU/misaligned ops; >=2 cycles for aligned memory ops.
// Backpressure: stall held high while a bus transfer is outstanding.
// Ports: EX/MEM inputs (alu_result_in, store_data_in, rd_in, memtoreg_in, we_in,
//        reg_en_in), stall to upstream, dmem_* bus, wb_* to MEM/WB, error pulses.
module mem_access_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [XLEN-1:0]       alu_result_in,
    input  logic [XLEN-1:0]       store_data_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  memtoreg_in,
    input  logic                  we_in,
    input  logic                  reg_en_in,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic [XLEN-1:0]       wb_result,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_reg_en,
    output logic                  wb_valid,
    output logic                  misalign_err,
    output logic                  bus_err
);

    mem_state_t            state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  reg_en_q, reg_en_d;
    logic                  load_q, load_d;
    logic [XLEN-1:0]       wb_result_q, wb_result_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic                  wb_reg_en_q, wb_reg_en_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  misalign_q, misalign_d;
    logic                  bus_err_q, bus_err_d;

    logic mem_op;
    logic aligned;
    logic timeout_hit;
    logic cnt_clr;
    logic cnt_en;
    logic stall_raw;

    assign mem_op  = memtoreg_in | we_in;
    assign aligned = is_word_aligned(alu_result_in[1:0]);

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset_n(reset_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (timeout_hit)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        reg_en_d    = reg_en_q;
        load_d      = load_q;
        wb_result_d = wb_result_q;
        wb_rd_d     = wb_rd_q;
        wb_reg_en_d = wb_reg_en_q;
        wb_valid_d  = wb_valid_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        stall_raw   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!mem_op) begin
                    wb_result_d = alu_result_in;
                    wb_rd_d     = rd_in;
                    wb_reg_en_d = reg_en_in;
                    wb_valid_d  = 1'b1;
                end else if (!aligned) begin
                    // Retire without touching the bus; suppress the register write.
                    wb_result_d = alu_result_in;
                    wb_rd_d     = rd_in;
                    wb_reg_en_d = 1'b0;
                    wb_valid_d  = 1'b1;
                    misalign_d  = 1'b1;
                end else begin
                    stall_raw   = 1'b1;
                    state_d     = BUSY;
                    req_d       = 1'b1;
                    we_d        = we_in;
                    addr_d      = alu_result_in;
                    wdata_d     = store_data_in;
                    rd_d        = rd_in;
                    reg_en_d    = reg_en_in;
                    // Load+store together is resolved as a store.
                    load_d      = memtoreg_in & ~we_in;
                    wb_valid_d  = 1'b0;
                    wb_reg_en_d = 1'b0;
                    cnt_clr     = 1'b1;
                end
            end
            BUSY: begin
                // Release upstream in the completing cycle so the next op lands next edge.
                stall_raw = ~dmem_ready & ~timeout_hit;
                if (dmem_ready) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (load_q) begin
                        wb_result_d = dmem_rdata;
                        wb_reg_en_d = reg_en_q;
                    end else begin
                        wb_result_d = addr_q;
                        wb_reg_en_d = 1'b0;
                    end
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    req_d       = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_rd_d     = rd_q;
                    wb_result_d = addr_q;
                    wb_reg_en_d = 1'b0;
                    bus_err_d   = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            reg_en_q    <= 1'b0;
            load_q      <= 1'b0;
            wb_result_q <= '0;
            wb_rd_q     <= '0;
            wb_reg_en_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            reg_en_q    <= reg_en_d;
            load_q      <= load_d;
            wb_result_q <= wb_result_d;
            wb_rd_q     <= wb_rd_d;
            wb_reg_en_q <= wb_reg_en_d;
            wb_valid_q  <= wb_valid_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // stall is combinational from the EX/MEM inputs, so force it low while in reset.
    assign stall        = stall_raw & reset_n;
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign wb_result    = wb_result_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_en    = wb_reg_en_q;
    assign wb_valid     = wb_valid_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

endmodule
